// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    // Bits needed to hold any value below 10^digits: ceil(log2(10^digits)).
    function automatic int bin_width(input int digits);
        longint p;
        int     w;
        p = 1;
        w = 0;
        for (int i = 0; i < digits; i++) p = p * 10;
        for (int i = 0; i < 40; i++) begin
            if ((longint'(1) << i) < p) w++;
        end
        return w;
    endfunction

    // A BCD nibble is only legal in 0..9.
    function automatic logic bcd_digit_invalid(input logic [3:0] digit);
        return digit > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction step of reverse double dabble: after a right shift a
// digit of 8 or more carried a "10" that must become "5", i.e. subtract 3.
module bcd_digit_adjust (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd8) ? digit - 4'd3 : digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one reverse-double-dabble shift per
// clock, with valid/ready handshakes on both sides and an invalid-digit flag.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = bin_width(DIGITS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] in_bcd,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BIN_W-1:0]              out_bin,
    output logic                          out_err,
    output logic                          busy
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);

    conv_state_t      state, state_nxt;
    logic [BCD_W-1:0] bcd_r;
    logic [BIN_W-1:0] bin_r;
    logic [CNT_W-1:0] cnt;
    logic             err_r;
    logic             in_err;
    logic             last_shift;
    logic [BCD_W-1:0] bcd_sh;
    logic [BCD_W-1:0] bcd_adj;

    assign last_shift = (cnt == CNT_W'(BIN_W - 1));

    // Flag the incoming word if any of its digits is outside 0..9.
    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_digit_invalid(in_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W])) in_err = 1'b1;
        end
    end

    // BCD side after the right shift; its LSB moves into the binary MSB.
    assign bcd_sh = {1'b0, bcd_r[BCD_W-1:1]};

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit    (bcd_sh[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .adjusted (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode: accept in IDLE, fixed BIN_W shifts, hold until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, shift/adjust while converting, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_r <= '0;
            bin_r <= '0;
            cnt   <= '0;
            err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    bcd_r <= in_bcd;
                    bin_r <= '0;
                    cnt   <= '0;
                    err_r <= in_err;
                end
                SHIFT: begin
                    bcd_r <= bcd_adj;
                    bin_r <= {bcd_r[0], bin_r[BIN_W-1:1]};
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs depend only on state and registers; a bad word still takes the
    // full latency so timing never reveals the input contents.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign out_err   = (state == DONE) && err_r;
    assign out_bin   = ((state == DONE) && !err_r) ? bin_r : '0;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench: vector table, random words against an arithmetic
// reference, plus hand-written handshake, stall and reset sequences.
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, out_err4, busy4;
    logic [15:0] in_bcd4 = '0;
    logic [13:0] out_bin4;

    logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1, out_err2, busy2;
    logic [7:0]  in_bcd2 = '0;
    logic [6:0]  out_bin2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_bcd(in_bcd4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_bin(out_bin4), .out_err(out_err4), .busy(busy4)
    );

    bcd_to_bin_seq #(.DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_bcd(in_bcd2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_bin(out_bin2), .out_err(out_err2), .busy(busy2)
    );

    typedef struct {
        logic [15:0] bcd;
        int          exp_bin;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: decimal value from digit weights; any nibble > 9 is an error.
    function automatic void ref_conv(input logic [31:0] b, input int nd,
                                     output int val, output bit err);
        int p;
        int d;
        val = 0;
        err = 1'b0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            d = int'(b[i*4 +: 4]);
            if (d > 9) err = 1'b1;
            val += d * p;
            p *= 10;
        end
        if (err) val = 0;
    endfunction

    function automatic logic [3:0] rand_digit();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    task automatic send4(input logic [15:0] b);
        int g;
        g = 0;
        in_bcd4 = b;
        in_valid4 = 1'b1;
        while (!in_ready4 && g < 50) begin @(posedge clk); #1; g++; end
        chk("d4_accept_ready", in_ready4, 1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic wait4(output int lat);
        lat = 0;
        while (!out_valid4 && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic run4(input logic [15:0] b, input int exp_bin, input bit exp_err, input string tag);
        int lat;
        send4(b);
        wait4(lat);
        chk({tag, "_latency"}, lat, 14);
        chk({tag, "_bin"}, out_bin4, exp_bin);
        chk({tag, "_err"}, out_err4, exp_err);
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, out_valid4, 0);
        chk({tag, "_idle_ready"}, in_ready4, 1);
    endtask

    task automatic run2(input logic [7:0] b, input int exp_bin, input bit exp_err, input string tag);
        int lat;
        int g;
        g = 0;
        in_bcd2 = b;
        in_valid2 = 1'b1;
        while (!in_ready2 && g < 50) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 40) begin @(posedge clk); #1; lat++; end
        chk({tag, "_latency"}, lat, 7);
        chk({tag, "_bin"}, out_bin2, exp_bin);
        chk({tag, "_err"}, out_err2, exp_err);
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, out_valid2, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   lat;
        int   rv;
        bit   re;
        logic [15:0] rb;

        vecs[0] = '{16'h9999, 9999, 1'b0};
        vecs[1] = '{16'h1234, 1234, 1'b0};
        vecs[2] = '{16'h0000,    0, 1'b0};
        vecs[3] = '{16'h12A4,    0, 1'b1};
        vecs[4] = '{16'h0042,   42, 1'b0};
        vecs[5] = '{16'h0001,    1, 1'b0};
        vecs[6] = '{16'h9000, 9000, 1'b0};
        vecs[7] = '{16'hF000,    0, 1'b1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready4, 1);
        chk("rst_out_valid", out_valid4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_out_bin", out_bin4, 0);
        chk("rst_out_err", out_err4, 0);
        chk("bin_width_4", bcd_pkg::bin_width(4), 14);
        chk("bin_width_2", bcd_pkg::bin_width(2), 7);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors.
        for (int i = 0; i < 8; i++)
            run4(vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err, $sformatf("vec%0d", i));

        // Back-to-back: next word presented during DONE, accepted one cycle after handshake.
        send4(16'h1234);
        wait4(lat);
        chk("b2b_first_latency", lat, 14);
        chk("b2b_first_bin", out_bin4, 1234);
        in_bcd4 = 16'h0000;
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        chk("b2b_bubble_idle", busy4, 0);
        chk("b2b_bubble_ready", in_ready4, 1);
        @(posedge clk); #1;
        chk("b2b_second_accept", busy4, 1);
        in_valid4 = 1'b0;
        wait4(lat);
        chk("b2b_second_latency", lat, 14);
        chk("b2b_second_bin", out_bin4, 0);
        chk("b2b_second_err", out_err4, 0);
        @(posedge clk); #1;

        // Consumer stall: outputs hold, in_valid pulses in DONE are ignored.
        out_ready4 = 1'b0;
        send4(16'h0987);
        wait4(lat);
        chk("stall_latency", lat, 14);
        for (int i = 0; i < 5; i++) begin
            in_valid4 = (i % 2 == 0);
            in_bcd4 = 16'h5555;
            @(posedge clk); #1;
            chk("stall_valid", out_valid4, 1);
            chk("stall_bin", out_bin4, 987);
            chk("stall_err", out_err4, 0);
            chk("stall_in_ready", in_ready4, 0);
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", out_valid4, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_no_stale_accept", busy4, 0);
        end

        // Asynchronous reset in the middle of a conversion.
        send4(16'h1234);
        repeat (6) @(posedge clk);
        #2;
        chk("midshift_busy", busy4, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready4, 1);
        chk("arst_out_valid", out_valid4, 0);
        chk("arst_busy", busy4, 0);
        chk("arst_out_bin", out_bin4, 0);
        chk("arst_out_err", out_err4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run4(16'h0500, 500, 1'b0, "post_reset");

        // Random words against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            rb = {rand_digit(), rand_digit(), rand_digit(), rand_digit()};
            ref_conv({16'h0, rb}, 4, rv, re);
            run4(rb, rv, re, $sformatf("rnd4_%0d_%h", i, rb));
        end

        // Two-digit build.
        run2(8'h99, 99, 1'b0, "d2_99");
        run2(8'h00, 0, 1'b0, "d2_00");
        run2(8'h9F, 0, 1'b1, "d2_9F");
        for (int i = 0; i < 10; i++) begin
            rb = {8'h00, rand_digit(), rand_digit()};
            ref_conv({16'h0, rb}, 2, rv, re);
            run2(rb[7:0], rv, re, $sformatf("rnd2_%0d_%h", i, rb[7:0]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
